e203_itcm_fetch_slv: RTL and testbench
======================================

E203_ITCM_FETCH_SLV -- requirements
Module: e203_itcm_fetch_slv

Interface
REQ-001 SHALL have parameter ITCM_AW, default 16, the ICB byte-address width.
REQ-002 SHALL have parameter ITCM_SIZE, default 32768, the populated ITCM bytes; addresses at or above it are errors.
REQ-003 SHALL have parameter RAM_AW, default 13, the 64-bit RAM word-address width, equal to ITCM_AW-3.
REQ-004 SHALL have port clk, input, 1, the single clock; all flops on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port icb_cmd_valid, input, 1, fetch command valid.
REQ-007 SHALL have port icb_cmd_ready, output, 1, fetch command accepted.
REQ-008 SHALL have port icb_cmd_addr, input, ITCM_AW, fetch byte address.
REQ-009 SHALL have port icb_rsp_valid, output, 1, response valid.
REQ-010 SHALL have port icb_rsp_ready, input, 1, response accepted.
REQ-011 SHALL have port icb_rsp_err, output, 1, out-of-range fetch.
REQ-012 SHALL have port icb_rsp_rdata, output, 64, the aligned 64-bit line.
REQ-013 SHALL have port ram_cs, output, 1, RAM read enable.
REQ-014 SHALL have port ram_addr, output, RAM_AW, equal to icb_cmd_addr[ITCM_AW-1:3].
REQ-015 SHALL have port ram_dout, input, 64, RAM read data, valid the cycle after ram_cs and held until the next ram_cs.
REQ-016 SHALL have port itcm_holdup, output, 1, RAM output still holds the last-read line.

Function
REQ-017 SHALL accept a command on icb_cmd_valid&icb_cmd_ready, with icb_cmd_ready = ~icb_rsp_valid | icb_rsp_ready, one outstanding fetch, back-to-back capable.
REQ-018 SHALL, for an accepted in-range command, assert ram_cs that cycle and icb_rsp_valid the next cycle (fixed 1-cycle latency) with rdata = ram_dout, err=0.
REQ-019 SHALL, for an accepted command with addr >= ITCM_SIZE, not assert ram_cs and return a response the next cycle with err=1, rdata=0.
REQ-020 SHALL track states IDLE (no response), RSP_LIVE (first response cycle, rdata from ram_dout), RSP_HELD (stalled, rdata from the 64-bit capture register).
REQ-021 SHALL transition RSP_LIVE->RSP_HELD when icb_rsp_ready=0, loading ram_dout into the capture register; RSP_HELD stays until icb_rsp_ready=1.
REQ-022 SHALL, on response handshake with a new command accepted in the same cycle, go to RSP_LIVE (or error response), else to IDLE.
REQ-023 SHALL keep icb_rsp_valid, icb_rsp_err and icb_rsp_rdata stable while stalled.
REQ-024 SHALL, with icb_cmd_valid=0, never assert ram_cs.

Reset
REQ-025 SHALL asynchronously reset to IDLE: icb_rsp_valid=0, icb_rsp_err=0, icb_rsp_rdata=0, ram_cs=0, itcm_holdup=0, capture register=0, last-line valid=0.
REQ-026 SHALL discard an in-flight fetch on reset mid-operation; no response after reset release.

Configuration
REQ-027 SHALL, with E203_ITCM_FETCH_HOLDUP_EN defined, record the last RAM word address and a valid bit; itcm_holdup=1 while valid and no ram_cs since.
REQ-028 SHALL, with E203_ITCM_FETCH_HOLDUP_EN defined, suppress ram_cs for an in-range command whose line matches the recorded address while itcm_holdup=1, responding from ram_dout with unchanged latency.
REQ-029 SHALL, without E203_ITCM_FETCH_HOLDUP_EN, assert ram_cs for every in-range command and tie itcm_holdup to 0.

Structure
REQ-030 SHALL place the state enum (IDLE, RSP_LIVE, RSP_HELD) and the 64-bit line-width constant in shared package e203_itcm_pkg.
REQ-031 SHALL contain one sub-module, e203_itcm_rsp_hold, implementing the capture register and rdata mux.

Verification
REQ-032 SHALL cover: cmd addr 0x0010, ram_dout=0x1122334455667788, rsp_ready=1 -> ram_cs, ram_addr=0x002, rsp next cycle with that rdata, err=0.
REQ-033 SHALL cover: addr 0x8000 -> no ram_cs, rsp next cycle err=1, rdata=0.
REQ-034 SHALL cover: rsp_ready=0 for 3 cycles, ram_dout changed -> rdata held at captured value, cmd_ready=0, released on ready=1.
REQ-035 SHALL cover: back-to-back cmds 0x0000, 0x0008 with ready=1 -> two responses on consecutive cycles, ram_addr 0x000, 0x001.
REQ-036 SHALL cover (HOLDUP_EN): cmd 0x0020 then idle then 0x0024 -> second has no ram_cs, itcm_holdup=1, same rdata.
REQ-037 SHALL cover: rst_n low during RSP_HELD -> all outputs 0 immediately, no stale response after release.

Source files
------------

// File: rtl/e203_itcm_pkg.sv
// Shared types and constants for the ITCM fetch slave.
package e203_itcm_pkg;

  // Width of one ITCM line as seen on the fetch response bus.
  localparam int LINE_W = 64;

  // Response-side state of the fetch slave.
  //   IDLE     : no response outstanding
  //   RSP_LIVE : first response cycle, data comes straight from the RAM
  //   RSP_HELD : response stalled, data comes from the capture register
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RSP_LIVE = 2'd1,
    RSP_HELD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/e203_itcm_rsp_hold.sv
// Response data holder for the ITCM fetch slave: captures the RAM line when
// the response is stalled in its first cycle and selects the line that is
// presented on the response bus.
module e203_itcm_rsp_hold
  import e203_itcm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  fetch_state_e      state,
  input  logic              rsp_ready,
  input  logic              err,
  input  logic [LINE_W-1:0] ram_dout,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] capture;

  // Snapshot the RAM output in the live cycle of a stalled response, because
  // the RAM may be re-read while the requester is still not ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      capture <= '0;
    end else if ((state == RSP_LIVE) && !rsp_ready) begin
      capture <= ram_dout;
    end
  end

  // Select live RAM data, held data, or zero for errors and idle.
  always_comb begin
    rdata = '0;
    if (!err) begin
      case (state)
        RSP_LIVE: rdata = ram_dout;
        RSP_HELD: rdata = capture;
        default:  rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/e203_itcm_fetch_slv.sv
// ITCM instruction-fetch ICB slave. Accepts one 64-bit line fetch at a time
// with a fixed one-cycle response latency, flags out-of-range fetches as
// errors, and holds response data stable across requester stalls.
// Optional feature macro: E203_ITCM_FETCH_HOLDUP_EN -- skip the RAM read when
// the requested line is still sitting on the RAM output.
module e203_itcm_fetch_slv
  import e203_itcm_pkg::*;
#(
  parameter int ITCM_AW   = 16,
  parameter int ITCM_SIZE = 32768,
  parameter int RAM_AW    = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic [ITCM_AW-1:0] icb_cmd_addr,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic              icb_rsp_err,
  output logic [LINE_W-1:0] icb_rsp_rdata,
  output logic              ram_cs,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [LINE_W-1:0] ram_dout,
  output logic              itcm_holdup
);

  // One extra bit so a size equal to the full address space still compares.
  localparam logic [ITCM_AW:0] SIZE_LIM = ITCM_SIZE[ITCM_AW:0];

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic         err_q;
  logic         err_d;
  logic         cmd_accept;
  logic         in_range;
  logic         line_hit;

  assign icb_rsp_valid = (state_q != IDLE);
  assign icb_rsp_err   = icb_rsp_valid & err_q;
  assign icb_cmd_ready = ~icb_rsp_valid | icb_rsp_ready;
  assign cmd_accept    = icb_cmd_valid & icb_cmd_ready;
  assign in_range      = ({1'b0, icb_cmd_addr} < SIZE_LIM);
  assign ram_addr      = icb_cmd_addr[ITCM_AW-1:3];
  assign ram_cs        = cmd_accept & in_range & ~line_hit;

`ifdef E203_ITCM_FETCH_HOLDUP_EN
  logic [RAM_AW-1:0] last_addr_q;
  logic              last_vld_q;

  // Remember which line the RAM output currently holds; every RAM read
  // replaces it, so the record stays valid until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr_q <= '0;
      last_vld_q  <= 1'b0;
    end else if (ram_cs) begin
      last_addr_q <= ram_addr;
      last_vld_q  <= 1'b1;
    end
  end

  assign itcm_holdup = last_vld_q;
  assign line_hit    = last_vld_q & (ram_addr == last_addr_q);
`else
  assign itcm_holdup = 1'b0;
  assign line_hit    = 1'b0;
`endif

  // Response state and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: a new command may be taken in the same cycle the
  // current response is handed off, giving back-to-back throughput.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          state_d = RSP_LIVE;
          err_d   = ~in_range;
        end
      end
      RSP_LIVE, RSP_HELD: begin
        if (icb_rsp_ready) begin
          if (cmd_accept) begin
            state_d = RSP_LIVE;
            err_d   = ~in_range;
          end else begin
            state_d = IDLE;
            err_d   = 1'b0;
          end
        end else begin
          state_d = RSP_HELD;
        end
      end
      default: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  e203_itcm_rsp_hold u_rsp_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .state     (state_q),
    .rsp_ready (icb_rsp_ready),
    .err       (err_q),
    .ram_dout  (ram_dout),
    .rdata     (icb_rsp_rdata)
  );

endmodule

// File: tb/tb_e203_itcm_fetch_slv.sv
// Self-checking bench for e203_itcm_fetch_slv: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_e203_itcm_fetch_slv;

  logic        clk;
  logic        rst_n;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [15:0] icb_cmd_addr;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic        icb_rsp_err;
  logic [63:0] icb_rsp_rdata;
  logic        ram_cs;
  logic [12:0] ram_addr;
  logic [63:0] ram_dout;
  logic        itcm_holdup;

  logic [63:0] mem [0:8191];
  logic [63:0] ram_q;
  logic [63:0] dout_noise;

  int vectors;
  int miscompares;

  // Reference model state: one outstanding response plus the RAM's last line.
  bit          m_pending;
  bit          m_err;
  logic [63:0] m_data;
  int          m_age;
  bit          m_last_vld;
  logic [12:0] m_last_word;

  e203_itcm_fetch_slv dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_err   (icb_rsp_err),
    .icb_rsp_rdata (icb_rsp_rdata),
    .ram_cs        (ram_cs),
    .ram_addr      (ram_addr),
    .ram_dout      (ram_dout),
    .itcm_holdup   (itcm_holdup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous RAM; noise models the output wandering while held.
  always @(posedge clk) begin
    if (ram_cs) ram_q <= mem[ram_addr];
  end
  assign ram_dout = ram_q ^ dout_noise;

  task automatic drive(input bit v, input logic [15:0] a, input bit rdy);
    @(negedge clk);
    icb_cmd_valid = v;
    icb_cmd_addr  = a;
    icb_rsp_ready = rdy;
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0; icb_cmd_valid = 1'b0; icb_rsp_ready = 1'b1; dout_noise = '0;
    #1;
    vectors++;
    if ({icb_rsp_valid, icb_rsp_err, ram_cs, itcm_holdup} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b required 0000", {icb_rsp_valid, icb_rsp_err, ram_cs, itcm_holdup});
    end
    vectors++;
    if (icb_rsp_rdata !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_rdata: got %h required 0", icb_rsp_rdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_fetch;
    drive(1'b1, 16'h0010, 1'b1);
    vectors++;
    if (ram_cs !== 1'b1 || ram_addr !== 13'h002) begin
      miscompares++;
      $display("[TB] FAIL single_cmd: ram_cs=%b ram_addr=%h required 1/002", ram_cs, ram_addr);
    end
    drive(1'b0, 16'h0, 1'b1);
    vectors++;
    if (icb_rsp_valid !== 1'b1 || icb_rsp_err !== 1'b0 || icb_rsp_rdata !== 64'h1122334455667788) begin
      miscompares++;
      $display("[TB] FAIL single_rsp: v=%b e=%b d=%h required 1/0/1122334455667788", icb_rsp_valid, icb_rsp_err, icb_rsp_rdata);
    end
    drive(1'b0, 16'h0, 1'b1);
    vectors++;
    if (icb_rsp_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_done: rsp_valid=%b required 0", icb_rsp_valid);
    end
  endtask

  task automatic test_error;
    drive(1'b1, 16'h8000, 1'b1);
    vectors++;
    if (ram_cs !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL err_cs: ram_cs=%b required 0", ram_cs);
    end
    drive(1'b0, 16'h0, 1'b1);
    vectors++;
    if (icb_rsp_valid !== 1'b1 || icb_rsp_err !== 1'b1 || icb_rsp_rdata !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL err_rsp: v=%b e=%b d=%h required 1/1/0", icb_rsp_valid, icb_rsp_err, icb_rsp_rdata);
    end
    idle_cycles(1);
  endtask

  task automatic test_stall;
    drive(1'b1, 16'h0010, 1'b0);
    drive(1'b0, 16'h0, 1'b0);
    vectors++;
    if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== mem[2] || icb_cmd_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_live: v=%b d=%h rdy=%b required 1/%h/0", icb_rsp_valid, icb_rsp_rdata, icb_cmd_ready, mem[2]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dout_noise = {$urandom, $urandom} | 64'h1;
      icb_cmd_valid = 1'b1;
      icb_cmd_addr = 16'h0100;
      #1;
      vectors++;
      if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== mem[2] || icb_cmd_ready !== 1'b0 || ram_cs !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_held: v=%b d=%h rdy=%b cs=%b required 1/%h/0/0", icb_rsp_valid, icb_rsp_rdata, icb_cmd_ready, ram_cs, mem[2]);
      end
    end
    drive(1'b0, 16'h0, 1'b1);
    vectors++;
    if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== mem[2] || icb_cmd_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stall_release: v=%b d=%h rdy=%b required 1/%h/1", icb_rsp_valid, icb_rsp_rdata, icb_cmd_ready, mem[2]);
    end
    @(negedge clk);
    dout_noise = '0;
    #1;
    vectors++;
    if (icb_rsp_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_done: rsp_valid=%b required 0", icb_rsp_valid);
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 16'h0000, 1'b1);
    vectors++;
    if (ram_cs !== 1'b1 || ram_addr !== 13'h000) begin
      miscompares++;
      $display("[TB] FAIL b2b_cmd0: cs=%b addr=%h required 1/000", ram_cs, ram_addr);
    end
    drive(1'b1, 16'h0008, 1'b1);
    vectors++;
    if (ram_cs !== 1'b1 || ram_addr !== 13'h001 || icb_cmd_ready !== 1'b1 ||
        icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== mem[0]) begin
      miscompares++;
      $display("[TB] FAIL b2b_cmd1: cs=%b addr=%h rdy=%b v=%b d=%h required 1/001/1/1/%h", ram_cs, ram_addr, icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, mem[0]);
    end
    drive(1'b0, 16'h0, 1'b1);
    vectors++;
    if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== mem[1]) begin
      miscompares++;
      $display("[TB] FAIL b2b_rsp1: v=%b d=%h required 1/%h", icb_rsp_valid, icb_rsp_rdata, mem[1]);
    end
    idle_cycles(1);
  endtask

  task automatic test_holdup;
    drive(1'b1, 16'h0020, 1'b1);
    vectors++;
    if (ram_cs !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL holdup_first_cs: cs=%b required 1", ram_cs);
    end
    idle_cycles(2);
    drive(1'b1, 16'h0024, 1'b1);
`ifdef E203_ITCM_FETCH_HOLDUP_EN
    vectors++;
    if (ram_cs !== 1'b0 || itcm_holdup !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL holdup_hit: cs=%b holdup=%b required 0/1", ram_cs, itcm_holdup);
    end
`else
    vectors++;
    if (ram_cs !== 1'b1 || itcm_holdup !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL holdup_off: cs=%b holdup=%b required 1/0", ram_cs, itcm_holdup);
    end
`endif
    drive(1'b0, 16'h0, 1'b1);
    vectors++;
    if (icb_rsp_valid !== 1'b1 || icb_rsp_err !== 1'b0 || icb_rsp_rdata !== mem[4]) begin
      miscompares++;
      $display("[TB] FAIL holdup_rsp: v=%b e=%b d=%h required 1/0/%h", icb_rsp_valid, icb_rsp_err, icb_rsp_rdata, mem[4]);
    end
    idle_cycles(1);
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 16'h0030, 1'b0);
    drive(1'b0, 16'h0, 1'b0);
    drive(1'b0, 16'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({icb_rsp_valid, icb_rsp_err, ram_cs, itcm_holdup} !== 4'b0000 || icb_rsp_rdata !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: v=%b e=%b cs=%b hu=%b d=%h required all 0", icb_rsp_valid, icb_rsp_err, ram_cs, itcm_holdup, icb_rsp_rdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h0, 1'b1);
      vectors++;
      if (icb_rsp_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_stale: rsp_valid=%b required 0 (cycle %0d)", icb_rsp_valid, i);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] a;
    bit v, rdy, exp_rdy, acc, inr, hit, exp_cs;
    logic [12:0] word;
    m_pending = 0; m_err = 0; m_data = '0; m_age = 0; m_last_vld = 0; m_last_word = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       a = 16'($urandom_range(16'h8000, 16'hFFFF));
        1, 2:    a = {11'h0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
        default: a = 16'($urandom_range(0, 16'h7FFF));
      endcase
      @(negedge clk);
      icb_cmd_valid = v;
      icb_cmd_addr  = a;
      icb_rsp_ready = rdy;
      dout_noise    = (m_pending && m_age > 0) ? {$urandom, $urandom} : 64'h0;
      #1;
      word    = a[15:3];
      exp_rdy = !m_pending || rdy;
      acc     = v && exp_rdy;
      inr     = (a < 16'h8000);
`ifdef E203_ITCM_FETCH_HOLDUP_EN
      hit     = m_last_vld && (word == m_last_word);
`else
      hit     = 1'b0;
`endif
      exp_cs  = acc && inr && !hit;
      vectors++;
      if (icb_cmd_ready !== exp_rdy || ram_cs !== exp_cs || ram_addr !== word) begin
        miscompares++;
        $display("[TB] FAIL rand_cmd c%0d: rdy=%b cs=%b addr=%h required %b/%b/%h", cyc, icb_cmd_ready, ram_cs, ram_addr, exp_rdy, exp_cs, word);
      end
      vectors++;
      if (icb_rsp_valid !== m_pending ||
          (m_pending && (icb_rsp_err !== m_err || icb_rsp_rdata !== m_data))) begin
        miscompares++;
        $display("[TB] FAIL rand_rsp c%0d: v=%b e=%b d=%h required %b/%b/%h", cyc, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata, m_pending, m_err, m_data);
      end
      vectors++;
`ifdef E203_ITCM_FETCH_HOLDUP_EN
      if (itcm_holdup !== m_last_vld) begin
`else
      if (itcm_holdup !== 1'b0) begin
`endif
        miscompares++;
        $display("[TB] FAIL rand_holdup c%0d: got %b", cyc, itcm_holdup);
      end
      if (m_pending && rdy) m_pending = 0;
      else if (m_pending) m_age++;
      if (acc) begin
        m_pending = 1;
        m_age     = 0;
        m_err     = !inr;
        m_data    = inr ? mem[word] : 64'h0;
      end
      if (exp_cs) begin
        m_last_vld  = 1;
        m_last_word = word;
      end
    end
    idle_cycles(2);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 8192; i++) mem[i] = {$urandom, $urandom};
    mem[2] = 64'h1122334455667788;
    ram_q = '0;
    dout_noise = '0;
    rst_n = 1'b0;
    icb_cmd_valid = 1'b0;
    icb_cmd_addr = '0;
    icb_rsp_ready = 1'b1;
    test_reset;
    test_single_fetch;
    test_error;
    test_stall;
    test_back_to_back;
    test_holdup;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
